// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, write ports, scoreboard allocation and soft clear.
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
);
  logic                clr;
  logic                ready;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NWR-1:0]      we;
  logic [NWR*AW-1:0]   wa;
  logic [NWR*XLEN-1:0] wd;
  logic                alloc_en;
  logic [AW-1:0]       alloc_rd;

  modport master (
    output clr, rs_addr, we, wa, wd, alloc_en, alloc_rd,
    input  ready, rs_data, rs_busy
  );

  modport slave (
    input  clr, rs_addr, we, wa, wd, alloc_en, alloc_rd,
    output ready, rs_data, rs_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with sequential clear sweep and per-register busy scoreboard.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned AW      = 5,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_X0 = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREG-1);

  state_t          state;
  logic [AW:0]     cnt;
  logic            ready_q;
  logic [NREG-1:0] busy;
  logic [XLEN-1:0] mem [NREG];

  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;

  assign bus.ready = ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      busy    <= '0;
    end else if (bus.clr) begin
      state   <= CLEAR;
      cnt     <= '0;
      ready_q <= 1'b0;
      busy    <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) begin
        state   <= RUN;
        ready_q <= 1'b1;
      end
    end else begin
      // Alloc is applied after the write clears so a same-cycle new producer wins.
      for (int unsigned j = 0; j < NWR; j++) begin
        if (bus.we[j]) busy[bus.wa[j*AW +: AW]] <= 1'b0;
      end
      if (bus.alloc_en && !(ZERO_X0 && bus.alloc_rd == '0))
        busy[bus.alloc_rd] <= 1'b1;
    end
  end

  // Storage has no reset; the CLEAR sweep zeroes one entry per edge.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt[AW-1:0]] <= '0;
    end else if (!bus.clr) begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (bus.we[j] && !(ZERO_X0 && bus.wa[j*AW +: AW] == '0))
          mem[bus.wa[j*AW +: AW]] <= bus.wd[j*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    rd_addr     = '0;
    rd_val      = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      rd_addr = bus.rs_addr[i*AW +: AW];
      rd_val  = mem[rd_addr];
      if (BYPASS) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (bus.we[j] && bus.wa[j*AW +: AW] == rd_addr)
            rd_val = bus.wd[j*XLEN +: XLEN];
        end
      end
      if ((ZERO_X0 && rd_addr == '0) || state != RUN)
        rd_val = '0;
      bus.rs_data[i*XLEN +: XLEN] = rd_val;
      bus.rs_busy[i]              = (state == RUN) && busy[rd_addr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (BYPASS=1 and BYPASS=0) share one stimulus.
module tb_regfile_mp;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) if0 ();
  regfile_mp_if #(.XLEN(32), .AW(5), .NRD(2), .NWR(2)) if1 ();

  assign if1.clr      = if0.clr;
  assign if1.rs_addr  = if0.rs_addr;
  assign if1.we       = if0.we;
  assign if1.wa       = if0.wa;
  assign if1.wd       = if0.wd;
  assign if1.alloc_en = if0.alloc_en;
  assign if1.alloc_rd = if0.alloc_rd;

  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(1'b1), .ZERO_X0(1'b1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  regfile_mp #(.XLEN(32), .NREG(32), .AW(5), .NRD(2), .NWR(2), .BYPASS(1'b0), .ZERO_X0(1'b1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  logic [31:0] a_p0, a_p1, b_p0, b_p1;
  logic [1:0]  a_busy, b_busy;
  logic        a_rdy, b_rdy;
  assign a_p0   = if0.rs_data[31:0];
  assign a_p1   = if0.rs_data[63:32];
  assign b_p0   = if1.rs_data[31:0];
  assign b_p1   = if1.rs_data[63:32];
  assign a_busy = if0.rs_busy;
  assign b_busy = if1.rs_busy;
  assign a_rdy  = if0.ready;
  assign b_rdy  = if1.ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if0.clr = 1'b0; if0.we = '0; if0.wa = '0; if0.wd = '0;
    if0.alloc_en = 1'b0; if0.alloc_rd = '0;
  endtask

  task automatic set_rd(input int r0, input int r1);
    if0.rs_addr = {5'(r1), 5'(r0)};
  endtask

  task automatic write1(input int r, input logic [31:0] v);
    if0.we = 2'b01; if0.wa = {5'd0, 5'(r)}; if0.wd = {32'h0, v};
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 32; r += 2) begin
      set_rd(r, r + 1);
      #1;
      vectors++;
      if ({a_p0, a_p1, b_p0, b_p1} !== 128'h0 || a_busy !== 2'b00 || b_busy !== 2'b00) begin
        miscompares++;
        $display("FAIL %s r%0d: a=%h/%h b=%h/%h busy=%b/%b, required all 0", tag, r,
                 a_p0, a_p1, b_p0, b_p1, a_busy, b_busy);
      end
    end
  endtask

  task automatic test_reset();
    idle(); set_rd(1, 2);
    rst_n = 1'b0;
    tick(); tick();
    vectors++;
    if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || a_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b/%b busy=%b, required 0/0 00", a_rdy, b_rdy, a_busy);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      if (e >= 10) begin
        if0.we = 2'b11; if0.wa = {5'd2, 5'd1}; if0.wd = {32'h2222_0000, 32'h1111_0000};
        if0.alloc_en = 1'b1; if0.alloc_rd = 5'd1;
      end
      #1;
      vectors++;
      if (a_p0 !== 32'h0 || a_p1 !== 32'h0 || b_p0 !== 32'h0 || a_busy !== 2'b00) begin
        miscompares++;
        $display("FAIL sweep_read e%0d: a=%h/%h b=%h busy=%b, required 0", e, a_p0, a_p1, b_p0, a_busy);
      end
      tick();
      vectors++;
      if (a_rdy !== (e == 32) || b_rdy !== (e == 32)) begin
        miscompares++;
        $display("FAIL sweep_ready e%0d: ready=%b/%b, required %b", e, a_rdy, b_rdy, e == 32);
      end
    end
    idle();
    check_all_zero("reset_array");
  endtask

  task automatic test_bypass();
    if0.we = 2'b11; if0.wa = {5'd5, 5'd5}; if0.wd = {32'h2222, 32'h1111};
    set_rd(5, 6);
    #1;
    vectors++;
    if (a_p0 !== 32'h2222 || b_p0 !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_same_addr: a=%h b=%h, required 00002222 00000000", a_p0, b_p0);
    end
    tick(); idle();
    #1;
    vectors++;
    if (a_p0 !== 32'h2222 || b_p0 !== 32'h2222) begin
      miscompares++;
      $display("FAIL write_priority: a=%h b=%h, required 00002222", a_p0, b_p0);
    end
    write1(6, 32'h3333);
    #1;
    vectors++;
    if (a_p1 !== 32'h3333 || b_p1 !== 32'h0) begin
      miscompares++;
      $display("FAIL bypass_single: a=%h b=%h, required 00003333 00000000", a_p1, b_p1);
    end
    tick(); idle();
    #1;
    vectors++;
    if (a_p1 !== 32'h3333 || b_p1 !== 32'h3333) begin
      miscompares++;
      $display("FAIL write_single: a=%h b=%h, required 00003333", a_p1, b_p1);
    end
  endtask

  task automatic test_zero_x0();
    write1(0, 32'hDEAD_BEEF);
    if0.alloc_en = 1'b1; if0.alloc_rd = 5'd0;
    set_rd(0, 0);
    #1;
    vectors++;
    if (a_p0 !== 32'h0 || b_p0 !== 32'h0) begin
      miscompares++;
      $display("FAIL x0_bypass: a=%h b=%h, required 0", a_p0, b_p0);
    end
    tick(); idle();
    #1;
    vectors++;
    if (a_p0 !== 32'h0 || b_p0 !== 32'h0 || a_busy !== 2'b00 || b_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL x0_write_alloc: a=%h b=%h busy=%b/%b, required 0", a_p0, b_p0, a_busy, b_busy);
    end
    write1(31, 32'hDEAD_BEEF);
    tick(); idle();
    set_rd(31, 31);
    #1;
    vectors++;
    if (a_p0 !== 32'hDEAD_BEEF || b_p1 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL x31_write: a=%h b=%h, required deadbeef", a_p0, b_p1);
    end
  endtask

  task automatic test_scoreboard();
    if0.alloc_en = 1'b1; if0.alloc_rd = 5'd7;
    set_rd(7, 7);
    #1;
    vectors++;
    if (a_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL alloc_same_cycle: busy=%b, required 00", a_busy);
    end
    tick(); idle();
    #1;
    vectors++;
    if (a_busy !== 2'b11 || b_busy !== 2'b11) begin
      miscompares++;
      $display("FAIL alloc_next_cycle: busy=%b/%b, required 11", a_busy, b_busy);
    end
    write1(7, 32'h77);
    if0.alloc_en = 1'b1; if0.alloc_rd = 5'd7;
    tick(); idle();
    #1;
    vectors++;
    if (a_busy[0] !== 1'b1 || b_busy[0] !== 1'b1 || a_p0 !== 32'h77 || b_p0 !== 32'h77) begin
      miscompares++;
      $display("FAIL write_alloc_same: busy=%b/%b data=%h/%h, required 1 00000077", a_busy[0], b_busy[0], a_p0, b_p0);
    end
    write1(7, 32'h78);
    #1;
    vectors++;
    if (a_busy[0] !== 1'b1 || a_p0 !== 32'h78 || b_p0 !== 32'h77) begin
      miscompares++;
      $display("FAIL busy_registered: busy=%b a=%h b=%h, required 1 00000078 00000077", a_busy[0], a_p0, b_p0);
    end
    tick(); idle();
    #1;
    vectors++;
    if (a_busy !== 2'b00 || b_busy !== 2'b00 || a_p0 !== 32'h78) begin
      miscompares++;
      $display("FAIL write_clears_busy: busy=%b/%b data=%h, required 00 00000078", a_busy, b_busy, a_p0);
    end
  endtask

  task automatic test_soft_clear();
    for (int k = 1; k < 32; k++) begin
      write1(k, 32'(k));
      tick();
    end
    idle();
    if0.alloc_en = 1'b1; if0.alloc_rd = 5'd3;
    tick(); idle();
    set_rd(3, 10);
    #1;
    vectors++;
    if (a_p1 !== 32'd10 || b_p0 !== 32'd3 || a_busy !== 2'b01) begin
      miscompares++;
      $display("FAIL fill: x10=%h x3=%h busy=%b, required 0000000a 00000003 01", a_p1, b_p0, a_busy);
    end
    if0.clr = 1'b1;
    tick();
    if0.clr = 1'b0;
    vectors++;
    if (a_rdy !== 1'b0 || a_busy !== 2'b00 || b_busy !== 2'b00 || a_p1 !== 32'h0) begin
      miscompares++;
      $display("FAIL clr_entry: ready=%b busy=%b/%b x10=%h, required 0 00 0", a_rdy, a_busy, b_busy, a_p1);
    end
    for (int e = 2; e <= 33; e++) begin
      tick();
      vectors++;
      if (a_rdy !== (e == 33) || b_rdy !== (e == 33)) begin
        miscompares++;
        $display("FAIL clr_ready e%0d: ready=%b/%b, required %b", e, a_rdy, b_rdy, e == 33);
      end
    end
    check_all_zero("clr_array");
    write1(5, 32'h55);
    tick(); idle();
    if0.clr = 1'b1;
    tick();
    if0.clr = 1'b0;
    for (int e = 1; e <= 10; e++) tick();
    vectors++;
    if (a_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL clr_mid_sweep: ready=%b, required 0", a_rdy);
    end
    if0.clr = 1'b1;
    tick();
    if0.clr = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      vectors++;
      if (a_rdy !== (e == 32) || b_rdy !== (e == 32)) begin
        miscompares++;
        $display("FAIL clr_restart e%0d: ready=%b/%b, required %b", e, a_rdy, b_rdy, e == 32);
      end
    end
    set_rd(5, 5);
    #1;
    vectors++;
    if (a_p0 !== 32'h0 || b_p1 !== 32'h0) begin
      miscompares++;
      $display("FAIL clr_restart_x5: a=%h b=%h, required 0", a_p0, b_p1);
    end
  endtask

  task automatic test_async_reset();
    write1(9, 32'h99);
    if0.alloc_en = 1'b1; if0.alloc_rd = 5'd3;
    tick(); idle();
    set_rd(3, 9);
    #1;
    vectors++;
    if (a_rdy !== 1'b1 || a_busy !== 2'b01 || a_p1 !== 32'h99) begin
      miscompares++;
      $display("FAIL pre_reset: ready=%b busy=%b x9=%h, required 1 01 00000099", a_rdy, a_busy, a_p1);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || a_busy !== 2'b00 || b_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL async_reset: ready=%b/%b busy=%b/%b, required 0 00", a_rdy, b_rdy, a_busy, b_busy);
    end
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick();
      vectors++;
      if (a_rdy !== (e == 32) || b_rdy !== (e == 32)) begin
        miscompares++;
        $display("FAIL reset_resweep e%0d: ready=%b/%b, required %b", e, a_rdy, b_rdy, e == 32);
      end
    end
    #1;
    vectors++;
    if (a_p1 !== 32'h0 || b_p1 !== 32'h0 || a_busy !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_array: x9=%h/%h busy=%b, required 0 00", a_p1, b_p1, a_busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    idle();
    set_rd(0, 0);
    test_reset();
    test_bypass();
    test_zero_x0();
    test_scoreboard();
    test_soft_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a built-in clear sequencer and a per-register busy scoreboard. It replaces the single-write, dual-read register file in the RV32I core and serves superscalar or multi-issue variants: NRD read ports, NWR write ports, optional write-to-read bypass and a hardwired-zero x0. Storage is cleared by a sequential sweep (one entry per cycle) instead of a wide asynchronous reset fan-out, so the array maps onto LUTRAM/flop arrays without a reset net.

## Interface
- XLEN, 32, data width
- NREG, 32, number of registers (power of two, ≥2)
- AW, 5, address width, clog2(NREG)
- NRD, 2, read ports
- NWR, 1, write ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- ZERO_X0, 1, 1 = register 0 reads 0, ignores writes, never busy

- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  synchronous soft clear request (pulse)
- ready  out  1  1 = RUN state, array valid, writes accepted
- rs_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rs_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rs_busy  out  NRD  busy bit of the addressed register, per port
- we  in  NWR  write enables
- wa  in  NWR*AW  write addresses
- wd  in  NWR*XLEN  write data
- alloc_en  in  1  mark alloc_rd busy (instruction issued with destination)
- alloc_rd  in  AW  destination being allocated

## Operation
- States: CLEAR, RUN. Counter cnt (AW+1 bits) is used only in CLEAR.
- Reset (rst_n=0): state=CLEAR, cnt=0, ready=0, all busy bits 0. Array contents are not reset.
- CLEAR: each edge writes 0 to entry cnt and increments cnt. The edge that clears entry NREG-1 sets state=RUN and ready=1. In CLEAR, we and alloc_en are ignored, rs_data=0 and rs_busy=0 for all ports.
- clr=1 sampled in RUN or CLEAR: next state=CLEAR, cnt=0, ready=0, all busy bits 0. Restarts the sweep if already clearing.
- RUN write: for each port j with we[j]=1 (and wa≠0 if ZERO_X0), entry wa[j] takes wd[j] at the edge. Same address on multiple ports: the highest index j wins.
- RUN read (combinational): rs_data[i] = array[rs_addr[i]].
  - If BYPASS=1 and some enabled write port in the same cycle targets rs_addr[i], the wd of the highest such port is returned instead.
  - With ZERO_X0=1, address 0 always returns 0.
- Scoreboard, RUN only:
  - An enabled write clears busy[wa[j]].
  - alloc_en sets busy[alloc_rd].
  - Same register written and allocated in one cycle: the set wins (new producer).
  - alloc to x0 is ignored when ZERO_X0=1.
- rs_busy[i] = busy[rs_addr[i]]. Registered view, not bypassed: a write in the current cycle clears the bit from the next cycle.

## Timing
- Read latency 0 (combinational). Write latency 1 edge. With BYPASS=0, a read of a register written in the same cycle returns the old value.
- ready goes high NREG rising edges after rst_n deasserts; the first write is accepted on edge NREG+1.
- After clr is sampled, ready is low for NREG+1 edges.
- Reset asserted mid-operation: ready, busy and state clear immediately (asynchronously); the array is swept again after release.

## Test plan
- Reset release, NREG=32: ready=0 for edges 1..31 and 1 after edge 32. During the sweep, every read port returns 0 and writes are dropped. After ready, all 32 registers read 0.
- NWR=2, RUN, we=2'b11, wa0=wa1=5, wd0=0x1111, wd1=0x2222 -> with BYPASS=1, the same-cycle read of 5 returns 0x2222; the next cycle reads 0x2222. Repeat with BYPASS=0 -> the same-cycle read returns the old value 0.
- ZERO_X0=1: write 0xDEADBEEF to x0 and alloc x0 -> x0 reads 0 and rs_busy=0. Write 0xDEADBEEF to x31 -> reads back 0xDEADBEEF.
- Scoreboard:
  - alloc x7 -> rs_busy=1 from the next cycle.
  - Write x7 with a simultaneous alloc x7 -> stays busy.
  - Write x7 alone -> busy=0 the cycle after.
- Soft clear: fill x1..x31 with their index, pulse clr mid-RUN -> ready=0 for 33 edges, busy bits 0, all registers 0 afterwards. A second clr in the middle of the sweep restarts the count (ready is delayed accordingly).
- Async reset asserted in RUN with x3 busy -> ready and rs_busy drop without waiting for a clock edge; the sweep runs again after release.
